rr_dispatcher: RTL and testbench
================================

// Module: rr_dispatcher
// PURPOSE
//  Round-robin work dispatcher: opposite direction of our round-robin arbiters (1 -> N instead of N -> 1).
//  Accepts items from a single producer over a valid/ready handshake and routes each to one of N consumers.
//  Consumers are visited in rotating order, skipping consumers that are disabled.
//  Sits at the fan-out side of a shared resource, e.g. spreading jobs over N identical engines.
// PARAMETERS
//  N   4  number of consumers (N >= 2)
//  DW  8  data width of one item
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous active-low reset, sampled on rising edge of clk
//  enable     in   1      1 = dispatcher may accept new items
//  dest_en    in   N      per-consumer enable mask; bit i = 0 -> consumer i is skipped
//  in_valid   in   1      producer has an item
//  in_data    in   DW     producer item
//  in_ready   out  1      dispatcher accepts in_data this cycle (in_valid & in_ready = accept)
//  out_valid  out  N      one-hot; bit i = item presented to consumer i
//  out_data   out  DW     item payload, shared by all consumers
//  out_ready  in   N      consumer i takes the item when out_valid[i] & out_ready[i]
//  busy       out  1      1 = an item is held in the output register
// BEHAVIOUR
//  Reset (rst_n = 0 at a clk edge): out_valid = 0, out_data = 0, busy = 0, in_ready = 0, ptr = 1 (consumer 0 highest).
//  State: IDLE (busy = 0) and HOLD (busy = 1).
//  - In IDLE, output register is empty.
//  - In HOLD, output register holds one item and its one-hot destination.
//  ptr: N-bit one-hot rotating priority.
//  - Selection: first set bit of dest_en at or after ptr, wrapping N-1 -> 0.
//  - Implemented as masked/unmasked priority pick, same method as our mask arbiter.
//  - sel = selected one-hot; sel = 0 when dest_en = 0.
//  out_fire = |(out_valid & out_ready).
//  in_ready = enable & (|dest_en) & (~busy | out_fire).
//  - Combinational, not a function of in_valid.
//  accept = in_valid & in_ready.
//  - On accept: out_data <= in_data, out_valid <= sel, busy <= 1, ptr <= sel rotated left by 1.
//  - So sel = bit N-1 gives ptr = bit 0.
//  - Latency: accepted in cycle t -> out_valid visible in cycle t+1.
//  out_fire & ~accept: out_valid <= 0, busy <= 0, out_data keeps its last value.
//  out_fire & accept (same cycle): new item replaces old one with no bubble; throughput 1 item/cycle.
//  HOLD without out_fire: out_valid and out_data stay stable until the consumer takes the item.
//  - dest_en, enable and in_valid changes do not alter a held item.
//  - No item is ever dropped or duplicated.
//  dest_en = 0: in_ready = 0; any held item still drains normally.
//  enable = 0: in_ready = 0; held item still drains.
//  - In the first cycle with enable = 0 and busy = 0, ptr returns to 1.
//  out_ready bits of consumers that are not addressed are ignored.
//  Reset asserted mid-transfer: held item is discarded and all state returns to reset values at that edge.
// TESTING
//  1. Reset, enable = 1, dest_en = 1111, all out_ready = 1, 8 items D0..D7 back-to-back
//     -> out_valid sequence 0001,0010,0100,1000,0001,... one per cycle, first at cycle+1; in_ready stays 1.
//  2. dest_en = 1010, 4 items -> destinations 0010,1000,0010,1000.
//  3. Item to consumer 2 with out_ready[2] = 0 for 5 cycles, in_valid held high
//     -> out_valid = 0100 and out_data stable; in_ready = 0 until out_ready[2] = 1.
//     -> In that cycle the next item is accepted; out_valid = 1000 next cycle.
//  4. dest_en = 0000, in_valid = 1 -> in_ready = 0, out_valid = 0.
//     -> Set dest_en = 0100 -> item goes to consumer 2.
//  5. Item held for consumer 1, drop enable -> item still delivered on out_ready[1], no new accepts.
//     -> After reenable the next item goes to consumer 0 (ptr reset).
//  6. rst_n = 0 while busy -> next cycle out_valid = 0, busy = 0, and the following items start at consumer 0.

Source files
------------

// File: rtl/rr_dispatcher.sv
// Round-robin 1->N work dispatcher with a one-item output register.
// Rotating one-hot priority skips consumers whose dest_en bit is clear.
module rr_dispatcher #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [N-1:0]  dest_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [N-1:0]  out_valid,
    output logic [DW-1:0] out_data,
    input  logic [N-1:0]  out_ready,
    output logic          busy
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e        state_q;
    logic [N-1:0]  ptr_q;
    logic [N-1:0]  ptr_d;
    logic [N-1:0]  out_valid_q;
    logic [DW-1:0] out_data_q;

    logic [N-1:0]  mask;
    logic [N-1:0]  masked;
    logic [N-1:0]  sel_m;
    logic [N-1:0]  sel_u;
    logic [N-1:0]  sel;
    logic          out_fire;
    logic          accept;

    // Bits at or above ptr first; fall back to lowest enabled bit on wrap.
    assign mask   = ~(ptr_q - N'(1));
    assign masked = dest_en & mask;
    assign sel_m  = masked & (~masked + N'(1));
    assign sel_u  = dest_en & (~dest_en + N'(1));
    assign sel    = (|masked) ? sel_m : sel_u;
    assign ptr_d  = {sel[N-2:0], sel[N-1]};

    assign out_fire = |(out_valid_q & out_ready);
    assign in_ready = rst_n & enable & (|dest_en)
                    & ((state_q == IDLE) | out_fire);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= N'(1);
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else if (accept) begin
            state_q     <= HOLD;
            ptr_q       <= ptr_d;
            out_valid_q <= sel;
            out_data_q  <= in_data;
        end else begin
            if (out_fire) begin
                state_q     <= IDLE;
                out_valid_q <= '0;
            end
            if (!enable && state_q == IDLE) begin
                ptr_q <= N'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_rr_dispatcher.sv
// Bench for rr_dispatcher: directed scenarios plus random traffic
// checked every cycle against an index-based queue model.
module tb_rr_dispatcher;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [N-1:0]  dest_en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference state: priority index, held item and its destination index.
    int            m_ptr;
    bit            m_hold;
    int            m_dst;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    rr_dispatcher #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .dest_en   (dest_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] den);
        for (int k = 0; k < N; k++) begin
            if (den[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input logic rst, input logic en,
                         input logic [N-1:0] den, input logic iv,
                         input logic [DW-1:0] id,
                         input logic [N-1:0] ordy);
        bit fire, rdy, acc;
        int s;
        rst_n     = rst;
        enable    = en;
        dest_en   = den;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        fire = m_hold && ordy[m_dst];
        rdy  = rst && en && (den != '0) && (!m_hold || fire);
        acc  = iv && rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (!rst) begin
            m_ptr  = 0;
            m_hold = 0;
            m_data = '0;
        end else if (acc) begin
            s      = pick(m_ptr, den);
            m_hold = 1;
            m_dst  = s;
            m_data = id;
            m_ptr  = (s + 1) % N;
        end else begin
            if (!en && !m_hold) m_ptr = 0;
            if (fire) m_hold = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid),
            m_hold ? (32'd1 << m_dst) : 32'd0);
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_hold));
    endtask

    initial begin
        logic [N-1:0] exp2 [4];
        logic [N-1:0] held;
        exp2 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        m_ptr = 0; m_hold = 0; m_dst = 0; m_data = '0;

        // Reset: in_ready low even with producer pushing.
        cycle(0, 1, 4'hF, 1, 8'hAA, 4'hF);
        cycle(0, 1, 4'hF, 1, 8'hAA, 4'hF);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Back-to-back over all consumers.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 4'hF, 1, 8'(8'hD0 + i), 4'hF);
            chk("t1_dst", 32'(out_valid), 32'd1 << (i % N));
        end
        cycle(1, 1, 4'hF, 0, 8'h00, 4'hF);

        // Skip disabled consumers.
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 4'b1010, 1, 8'(8'h20 + i), 4'hF);
            chk("t2_dst", 32'(out_valid), 32'(exp2[i]));
        end
        cycle(1, 1, 4'hF, 0, 8'h00, 4'hF);

        // Backpressure on consumer 2.
        cycle(1, 1, 4'b0100, 1, 8'h33, 4'h0);
        chk("t3_dst", 32'(out_valid), 32'b0100);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 4'hF, 1, 8'h44, 4'b1011);
        end
        cycle(1, 1, 4'hF, 1, 8'h44, 4'b0100);
        chk("t3_next", 32'(out_valid), 32'b1000);
        chk("t3_data", 32'(out_data), 32'h44);
        cycle(1, 1, 4'hF, 0, 8'h00, 4'hF);

        // No enabled destination.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 4'h0, 1, 8'h55, 4'hF);
        end
        cycle(1, 1, 4'b0100, 1, 8'h55, 4'hF);
        chk("t4_dst", 32'(out_valid), 32'b0100);
        cycle(1, 1, 4'hF, 0, 8'h00, 4'hF);

        // Disable while holding; pointer returns to consumer 0.
        cycle(1, 1, 4'b0010, 1, 8'h66, 4'h0);
        chk("t5_dst", 32'(out_valid), 32'b0010);
        cycle(1, 0, 4'hF, 1, 8'h77, 4'h0);
        cycle(1, 0, 4'hF, 1, 8'h77, 4'b1101);
        cycle(1, 0, 4'hF, 1, 8'h77, 4'b0010);
        chk("t5_drain", 32'(busy), 32'd0);
        cycle(1, 0, 4'hF, 1, 8'h77, 4'hF);
        cycle(1, 1, 4'hF, 1, 8'h78, 4'h0);
        chk("t5_ptr", 32'(out_valid), 32'b0001);
        cycle(1, 1, 4'hF, 0, 8'h00, 4'hF);

        // Reset while busy.
        cycle(1, 1, 4'hF, 1, 8'h81, 4'h0);
        cycle(1, 1, 4'hF, 1, 8'h82, 4'h0);
        held = out_valid;
        chk("t6_held", 32'(held != '0), 32'd1);
        cycle(0, 1, 4'hF, 1, 8'h83, 4'h0);
        chk("t6_rst", 32'(out_valid), 32'd0);
        cycle(1, 1, 4'hF, 1, 8'h84, 4'hF);
        chk("t6_first", 32'(out_valid), 32'b0001);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 7) != 0),
                  4'($urandom),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
